// File: rtl/burt_window_streamer.sv
// rtl/burt_window_streamer.sv - dilated horizontal window generator with border replication
module burt_window_streamer #(
  parameter int DATA_WIDTH   = 16,
  parameter int TAPS         = 5,
  parameter int MAX_DILATION = 4,
  parameter int DIL_WIDTH    = $clog2(MAX_DILATION + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [DATA_WIDTH-1:0]            pixel_i,
  input  logic [15:0]                      col_i,
  input  logic [15:0]                      row_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [15:0]                      width_i,
  input  logic [DIL_WIDTH-1:0]             dilation_i,
  output logic [TAPS-1:0][DATA_WIDTH-1:0]  window_o,
  output logic [15:0]                      col_o,
  output logic [15:0]                      row_o,
  output logic                             valid_o
);

  localparam int H = (TAPS - 1) / 2;
  localparam int L = (TAPS - 1) * MAX_DILATION + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t state_q, state_d;

  // sr_q[0] is the newest sample; older samples sit at higher indices.
  logic [DATA_WIDTH-1:0] sr_q [L];
  logic [DATA_WIDTH-1:0] sr_d [L];

  // x is the virtual column of the newest sample, counting flush duplicates.
  logic [15:0] x_q, x_d;
  logic [15:0] w_q, w_d;
  logic [15:0] d_q, d_d;
  logic [15:0] hd_q, hd_d;
  logic [15:0] row_q, row_d;
  logic [15:0] cnt_q, cnt_d;

  logic [TAPS-1:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [15:0] col_out_q, col_out_d;
  logic [15:0] row_out_q, row_out_d;
  logic        valid_q, valid_d;

  logic                  accept;
  logic                  start;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic [15:0]           dil_ext;
  logic [15:0]           d_clamp;
  logic [15:0]           hd_calc;
  logic [31:0]           tap_off;
  logic [15:0]           tap_idx;

  // Stop accepting while flushing the right border or while held in reset.
  assign ready_o = !rst_i && (state_q != S_FLUSH);
  assign accept  = valid_i && ready_o;
  assign start   = accept && (col_i == 16'd0);

  // Normalise the requested dilation: 0 acts as 1, oversize values saturate.
  always_comb begin
    dil_ext = {{(16-DIL_WIDTH){1'b0}}, dilation_i};
    d_clamp = dil_ext;
    if (dil_ext == 16'd0) begin
      d_clamp = 16'd1;
    end else if (dil_ext > 16'(MAX_DILATION)) begin
      d_clamp = 16'(MAX_DILATION);
    end
    hd_calc = 16'(H) * d_clamp;
  end

  // Row sequencing: decides when to push, what to push and where the row ends.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    w_d       = w_q;
    d_d       = d_q;
    hd_d      = hd_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_data = pixel_i;

    if (start) begin
      // A column-0 pixel always opens a fresh row, even mid-row.
      w_d   = width_i;
      d_d   = d_clamp;
      hd_d  = hd_calc;
      row_d = row_i;
      x_d   = 16'd0;
      push  = 1'b1;
      if (width_i <= 16'd1) begin
        if (hd_calc == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FLUSH;
          cnt_d   = hd_calc;
        end
      end else begin
        state_d = S_RUN;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (accept) begin
            push = 1'b1;
            x_d  = x_q + 16'd1;
            if (col_i == w_q - 16'd1) begin
              if (hd_q == 16'd0) begin
                state_d = S_IDLE;
              end else begin
                state_d = S_FLUSH;
                cnt_d   = hd_q;
              end
            end
          end
        end
        S_FLUSH: begin
          // Re-push the last real pixel to replicate the right border.
          push      = 1'b1;
          push_data = sr_q[0];
          x_d       = x_q + 16'd1;
          cnt_d     = cnt_q - 16'd1;
          if (cnt_q <= 16'd1) begin
            state_d = S_IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Shift in the pushed sample and form the window once the right tap is filled.
  always_comb begin
    sr_d      = sr_q;
    win_d     = win_q;
    col_out_d = col_out_q;
    row_out_d = row_out_q;
    valid_d   = 1'b0;
    tap_off   = 32'd0;
    tap_idx   = 16'd0;

    if (push) begin
      sr_d[0] = push_data;
      for (int i = 1; i < L; i++) begin
        sr_d[i] = sr_q[i-1];
      end
      if (x_d >= hd_d) begin
        valid_d   = 1'b1;
        col_out_d = x_d - hd_d;
        row_out_d = row_d;
        for (int k = 0; k < TAPS; k++) begin
          // Clamping the lookback to x replicates the left border pixel.
          tap_off = 32'(TAPS - 1 - k) * 32'(d_d);
          tap_idx = (tap_off > {16'd0, x_d}) ? x_d : tap_off[15:0];
          for (int j = 0; j < L; j++) begin
            if (16'(j) == tap_idx) begin
              win_d[k] = sr_d[j];
            end
          end
        end
      end
    end
  end

  // Control state and row parameters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      x_q     <= 16'd0;
      w_q     <= 16'd1;
      d_q     <= 16'd1;
      hd_q    <= 16'd0;
      row_q   <= 16'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      d_q     <= d_d;
      hd_q    <= hd_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pixel history; stale contents are masked by x, so no reset is needed.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < L; i++) begin
      sr_q[i] <= sr_d[i];
    end
  end

  // Registered window outputs; values hold between valid pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_q     <= '0;
      col_out_q <= 16'd0;
      row_out_q <= 16'd0;
      valid_q   <= 1'b0;
    end else begin
      win_q     <= win_d;
      col_out_q <= col_out_d;
      row_out_q <= row_out_d;
      valid_q   <= valid_d;
    end
  end

  assign window_o = win_q;
  assign col_o    = col_out_q;
  assign row_o    = row_out_q;
  assign valid_o  = valid_q;

endmodule
